// File: rtl/eeprom_i2c_slave.sv
// 24C08-style I2C EEPROM responder (1 KB, 16-byte write pages).
// Open-drain SDA, never stretches SCL, byte-wide synchronous memory port.
module eeprom_i2c_slave #(
  parameter logic [4:0] DEV_ADDR_HI = 5'b10100,
  parameter int         PAGE_BITS   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_out_en,
  input  logic       wp,
  output logic [9:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       mem_re,
  input  logic [7:0] mem_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_DEV_ACK, S_WADDR, S_WADDR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_WAIT_STOP
  } state_t;

  state_t      state_q, state_d;
  logic        scl_m_q, scl_s_q, scl_h_q;
  logic        sda_m_q, sda_s_q, sda_h_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  sr_q, sr_d;
  logic [9:0]  ptr_q, ptr_d;
  logic        oe_q, oe_d;
  logic        rw_q, rw_d;
  logic        ack_q, ack_d;
  logic        pend_q, pend_d;
  logic        ld_q, ld_d;
  logic [9:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        re_q, re_d;

  logic scl_rise, scl_fall, start_c, stop_c;

  assign scl_rise = scl_s_q & ~scl_h_q;
  assign scl_fall = ~scl_s_q & scl_h_q;
  assign start_c  = scl_s_q & scl_h_q & sda_h_q & ~sda_s_q;
  assign stop_c   = scl_s_q & scl_h_q & ~sda_h_q & sda_s_q;

  assign sda_out    = 1'b0;
  assign sda_out_en = oe_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_we     = we_q;
  assign mem_re     = re_q;
  assign busy       = (state_q != S_IDLE);

  // Synchronize the bus pins and keep one sample of history for edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_m_q <= 1'b1; scl_s_q <= 1'b1; scl_h_q <= 1'b1;
      sda_m_q <= 1'b1; sda_s_q <= 1'b1; sda_h_q <= 1'b1;
    end else begin
      scl_m_q <= scl_in; scl_s_q <= scl_m_q; scl_h_q <= scl_s_q;
      sda_m_q <= sda_in; sda_s_q <= sda_m_q; sda_h_q <= sda_s_q;
    end
  end

  // Protocol state and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      ptr_q   <= '0;
      oe_q    <= 1'b0;
      rw_q    <= 1'b0;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
      ld_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      ptr_q   <= ptr_d;
      oe_q    <= oe_d;
      rw_q    <= rw_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
      ld_q    <= ld_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
    end
  end

  // Next-state decode; all SDA changes happen on a detected SCL fall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    ptr_d   = ptr_q;
    oe_d    = oe_q;
    rw_d    = rw_q;
    ack_d   = ack_q;
    pend_d  = 1'b0;
    ld_d    = re_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = pend_q;
    if (pend_q) addr_d = ptr_q;
    if (ld_q) sr_d = mem_rdata;

    if (start_c) begin
      state_d = S_DEV;
      cnt_d   = '0;
      oe_d    = 1'b0;
      re_d    = 1'b0;
    end else if (stop_c) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      re_d    = 1'b0;
    end else begin
      case (state_q)
        S_DEV, S_WADDR, S_WDATA: begin
          if (scl_rise && cnt_q != 4'd8) begin
            sr_d  = {sr_q[6:0], sda_s_q};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            case (state_q)
              S_DEV: begin
                if (sr_q[7:3] == DEV_ADDR_HI) begin
                  state_d    = S_DEV_ACK;
                  oe_d       = 1'b1;
                  ptr_d[9:8] = sr_q[2:1];
                  rw_d       = sr_q[0];
                  pend_d     = sr_q[0];
                end else begin
                  state_d = S_WAIT_STOP;
                end
              end
              S_WADDR: begin
                state_d    = S_WADDR_ACK;
                oe_d       = 1'b1;
                ptr_d[7:0] = sr_q;
              end
              default: begin
                if (wp) begin
                  state_d = S_WAIT_STOP;
                end else begin
                  state_d = S_WDATA_ACK;
                  oe_d    = 1'b1;
                end
              end
            endcase
          end
        end
        S_DEV_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              state_d = S_RDATA;
              oe_d    = ~sr_q[7];
              sr_d    = {sr_q[6:0], 1'b0};
              cnt_d   = 4'd1;
            end else begin
              state_d = S_WADDR;
              oe_d    = 1'b0;
              cnt_d   = '0;
            end
          end
        end
        S_WADDR_ACK: begin
          if (scl_fall) begin
            state_d = S_WDATA;
            oe_d    = 1'b0;
            cnt_d   = '0;
          end
        end
        S_WDATA_ACK: begin
          if (scl_rise) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = sr_q;
            ptr_d[PAGE_BITS-1:0] = ptr_q[PAGE_BITS-1:0] + 1'b1;
          end else if (scl_fall) begin
            state_d = S_WDATA;
            oe_d    = 1'b0;
            cnt_d   = '0;
          end
        end
        S_RDATA: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d = S_RACK;
              oe_d    = 1'b0;
            end else begin
              oe_d  = ~sr_q[7];
              sr_d  = {sr_q[6:0], 1'b0};
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        S_RACK: begin
          if (scl_rise) begin
            ptr_d  = ptr_q + 10'd1;
            ack_d  = ~sda_s_q;
            pend_d = ~sda_s_q;
          end else if (scl_fall) begin
            if (ack_q) begin
              state_d = S_RDATA;
              oe_d    = ~sr_q[7];
              sr_d    = {sr_q[6:0], 1'b0};
              cnt_d   = 4'd1;
            end else begin
              state_d = S_WAIT_STOP;
              oe_d    = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_i2c_slave.sv
// Directed bench for eeprom_i2c_slave: bit-banged I2C master
// plus a 1 KB memory model with strobe logging.
module tb_eeprom_i2c_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       wp = 1'b0;
  logic       sda_out, sda_out_en;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we, mem_re;
  logic [7:0] mem_rdata = 8'h00;
  logic       busy;
  logic       sda_line;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [0:1023];
  logic       pl_we = 1'b0;
  logic [9:0] pl_addr = '0;
  logic [7:0] pl_data = '0;

  int         we_n = 0, re_n = 0, both_n = 0, drv_n = 0;
  logic [9:0] we_a [0:63];
  logic [7:0] we_d [0:63];
  logic [9:0] re_a [0:63];

  assign sda_line = sda_m & ~sda_out_en;

  always #5 clk = ~clk;

  eeprom_i2c_slave dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_m), .sda_in(sda_line),
    .sda_out(sda_out), .sda_out_en(sda_out_en), .wp(wp),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy)
  );

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we && we_n < 64) begin
      we_a[we_n] <= mem_addr;
      we_d[we_n] <= mem_wdata;
    end
    if (mem_we) we_n <= we_n + 1;
    if (mem_re && re_n < 64) re_a[re_n] <= mem_addr;
    if (mem_re) re_n <= re_n + 1;
    if (mem_we && mem_re) both_n <= both_n + 1;
    if (sda_out_en) drv_n <= drv_n + 1;
  end

  task automatic q();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_we = 1'b1;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic bitx(input logic b, output logic r);
    sda_m = b; q();
    scl_m = 1'b1; q();
    r = sda_line; q();
    scl_m = 1'b0; q();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    sda_m = 1'b0; q();
    scl_m = 1'b0; q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; q();
    scl_m = 1'b1; q();
    sda_m = 1'b1; q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bitx(b[i], r);
    bitx(1'b1, r);
    ack = ~r;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      bitx(1'b1, r);
      d = {d[6:0], r};
    end
    bitx(nack, r);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    if ({sda_out_en, busy, mem_we, mem_re} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctl got %b exp 0000",
               {sda_out_en, busy, mem_we, mem_re});
    end
    n_tests++;
    if (mem_addr !== 10'h000 || mem_wdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mem got %h/%h exp 000/00", mem_addr, mem_wdata);
    end
    n_tests++;
    if (sda_out !== 1'b0) begin
      n_fail++;
      $display("FAIL sda_out got %b exp 0", sda_out);
    end
    n_tests++;
    rst_n = 1'b1;
    q();
  endtask

  task automatic test_byte_write();
    logic a0, a1, a2;
    int wb;
    wb = we_n;
    i2c_start();
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start got %b exp 1", busy);
    end
    n_tests++;
    send_byte(8'hA2, a0);
    send_byte(8'h34, a1);
    send_byte(8'h5A, a2);
    i2c_stop();
    q();
    if ({a0, a1, a2} !== 3'b111) begin
      n_fail++;
      $display("FAIL bw_acks got %b exp 111", {a0, a1, a2});
    end
    n_tests++;
    if (we_n - wb != 1) begin
      n_fail++;
      $display("FAIL bw_count got %0d exp 1", we_n - wb);
    end
    n_tests++;
    if (we_a[wb] !== 10'h134 || we_d[wb] !== 8'h5A) begin
      n_fail++;
      $display("FAIL bw_write got %h/%h exp 134/5a", we_a[wb], we_d[wb]);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_stop got %b exp 0", busy);
    end
    n_tests++;
  endtask

  task automatic test_random_read();
    logic a0, a1, a2;
    logic [7:0] d;
    int rb;
    preload(10'h134, 8'h5A);
    rb = re_n;
    i2c_start();
    send_byte(8'hA2, a0);
    send_byte(8'h34, a1);
    i2c_start();
    send_byte(8'hA3, a2);
    recv_byte(1'b1, d);
    i2c_stop();
    q();
    if ({a0, a1, a2} !== 3'b111) begin
      n_fail++;
      $display("FAIL rr_acks got %b exp 111", {a0, a1, a2});
    end
    n_tests++;
    if (d !== 8'h5A) begin
      n_fail++;
      $display("FAIL rr_data got %h exp 5a", d);
    end
    n_tests++;
    if (re_n - rb != 1 || re_a[rb] !== 10'h134) begin
      n_fail++;
      $display("FAIL rr_re got %0d@%h exp 1@134", re_n - rb, re_a[rb]);
    end
    n_tests++;
  endtask

  task automatic test_page_wrap();
    logic a;
    logic ok;
    int wb;
    logic [9:0] ea [4];
    logic [7:0] ed [4];
    ea = '{10'h01E, 10'h01F, 10'h010, 10'h011};
    ed = '{8'h11, 8'h22, 8'h33, 8'h44};
    ok = 1'b1;
    wb = we_n;
    i2c_start();
    send_byte(8'hA0, a); ok &= a;
    send_byte(8'h1E, a); ok &= a;
    for (int i = 0; i < 4; i++) begin
      send_byte(ed[i], a);
      ok &= a;
    end
    i2c_stop();
    q();
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL pw_acks got %b exp 1", ok);
    end
    n_tests++;
    if (we_n - wb != 4) begin
      n_fail++;
      $display("FAIL pw_count got %0d exp 4", we_n - wb);
    end
    n_tests++;
    for (int i = 0; i < 4; i++) begin
      if (we_a[wb+i] !== ea[i] || we_d[wb+i] !== ed[i]) begin
        n_fail++;
        $display("FAIL pw_write%0d got %h/%h exp %h/%h",
                 i, we_a[wb+i], we_d[wb+i], ea[i], ed[i]);
      end
      n_tests++;
    end
  endtask

  task automatic test_seq_read_wrap();
    logic a0, a1, a2, a3;
    logic [7:0] d0, d1, d2;
    int rb;
    preload(10'h3FF, 8'hC3);
    preload(10'h000, 8'h3C);
    preload(10'h001, 8'h5E);
    rb = re_n;
    i2c_start();
    send_byte(8'hA6, a0);
    send_byte(8'hFF, a1);
    i2c_start();
    send_byte(8'hA7, a2);
    recv_byte(1'b0, d0);
    recv_byte(1'b1, d1);
    i2c_stop();
    i2c_start();
    send_byte(8'hA1, a3);
    recv_byte(1'b1, d2);
    i2c_stop();
    q();
    if ({a0, a1, a2, a3} !== 4'b1111) begin
      n_fail++;
      $display("FAIL sr_acks got %b exp 1111", {a0, a1, a2, a3});
    end
    n_tests++;
    if ({d0, d1, d2} !== 24'hC33C5E) begin
      n_fail++;
      $display("FAIL sr_data got %h exp c33c5e", {d0, d1, d2});
    end
    n_tests++;
    if (re_n - rb != 3) begin
      n_fail++;
      $display("FAIL sr_count got %0d exp 3", re_n - rb);
    end
    n_tests++;
    if ({re_a[rb], re_a[rb+1], re_a[rb+2]} !== {10'h3FF, 10'h000, 10'h001}) begin
      n_fail++;
      $display("FAIL sr_addr got %h %h %h exp 3ff 000 001",
               re_a[rb], re_a[rb+1], re_a[rb+2]);
    end
    n_tests++;
  endtask

  task automatic test_mismatch();
    logic a;
    int wb, rb, db;
    wb = we_n; rb = re_n; db = drv_n;
    i2c_start();
    send_byte(8'hB0, a);
    i2c_stop();
    q();
    if (a !== 1'b0) begin
      n_fail++;
      $display("FAIL mm_ack got %b exp 0", a);
    end
    n_tests++;
    if (drv_n != db || we_n != wb || re_n != rb) begin
      n_fail++;
      $display("FAIL mm_quiet got drv%0d we%0d re%0d exp 0 0 0",
               drv_n - db, we_n - wb, re_n - rb);
    end
    n_tests++;
  endtask

  task automatic test_wp();
    logic a0, a1, a2;
    int wb;
    wb = we_n;
    wp = 1'b1;
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'h10, a1);
    send_byte(8'h77, a2);
    i2c_stop();
    q();
    wp = 1'b0;
    if ({a0, a1, a2} !== 3'b110) begin
      n_fail++;
      $display("FAIL wp_acks got %b exp 110", {a0, a1, a2});
    end
    n_tests++;
    if (we_n != wb) begin
      n_fail++;
      $display("FAIL wp_we got %0d exp 0", we_n - wb);
    end
    n_tests++;
  endtask

  task automatic test_abort();
    logic a0, a1, a2, r;
    logic [7:0] d;
    int wb, rb;
    preload(10'h040, 8'h99);
    wb = we_n; rb = re_n;
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'h40, a1);
    bitx(1'b1, r); bitx(1'b0, r); bitx(1'b1, r); bitx(1'b1, r);
    i2c_start();
    send_byte(8'hA1, a2);
    recv_byte(1'b1, d);
    i2c_stop();
    q();
    if ({a0, a1, a2} !== 3'b111) begin
      n_fail++;
      $display("FAIL ab_acks got %b exp 111", {a0, a1, a2});
    end
    n_tests++;
    if (we_n != wb) begin
      n_fail++;
      $display("FAIL ab_we got %0d exp 0", we_n - wb);
    end
    n_tests++;
    if (re_n - rb != 1 || re_a[rb] !== 10'h040 || d !== 8'h99) begin
      n_fail++;
      $display("FAIL ab_read got %0d@%h=%h exp 1@040=99",
               re_n - rb, re_a[rb], d);
    end
    n_tests++;
  endtask

  task automatic test_reset_mid_read();
    logic a, r;
    logic [7:0] d;
    int rb;
    preload(10'h041, 8'h00);
    i2c_start();
    send_byte(8'hA1, a);
    bitx(1'b1, r);
    bitx(1'b1, r);
    if (sda_out_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_drive got %b exp 1", sda_out_en);
    end
    n_tests++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    if (sda_out_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_reset got oe%b busy%b exp 0 0", sda_out_en, busy);
    end
    n_tests++;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    q();
    i2c_stop();
    rb = re_n;
    i2c_start();
    send_byte(8'hA1, a);
    recv_byte(1'b1, d);
    i2c_stop();
    q();
    if (re_n - rb != 1 || re_a[rb] !== 10'h000 || d !== 8'h3C) begin
      n_fail++;
      $display("FAIL rm_ptr got %0d@%h=%h exp 1@000=3c",
               re_n - rb, re_a[rb], d);
    end
    n_tests++;
  endtask

  task automatic test_strobe_excl();
    if (both_n != 0) begin
      n_fail++;
      $display("FAIL we_re_overlap got %0d exp 0", both_n);
    end
    n_tests++;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_byte_write();
    test_random_read();
    test_page_wrap();
    test_seq_read_wrap();
    test_mismatch();
    test_wp();
    test_abort();
    test_reset_mid_read();
    test_strobe_excl();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
